// File: rtl/core_lsu.sv
// core_lsu: load/store unit between execute and the arbiter's LSU port.
// Checks funct3 and alignment on accept, issues one word-aligned request,
// extracts/extends load data and returns a single done or fault pulse.
`timescale 1ns/1ps
module core_lsu #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_is_store,
    input  logic [2:0]    i_funct3,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic [4:0]    i_rd,
    output logic          o_mem_read,
    output logic          o_mem_write,
    output logic [AW-1:0] o_mem_addr,
    output logic [3:0]    o_mem_byte_en,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_grant,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_done,
    output logic          o_rd_we,
    output logic [4:0]    o_rd,
    output logic [DW-1:0] o_rdata,
    output logic          o_fault,
    output logic [1:0]    o_fault_cause
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT_R = 3'd2,
        S_RESP   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    // Counter only needs to reach TIMEOUT-1; it parks there so that a grant
    // on the last cycle followed by a late rvalid still gets one final chance.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic [1:0]    cause_q, cause_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_store_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [4:0]    rd_q;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          accept;
    logic          illegal_in;
    logic          misalign_in;
    logic          tmo_last;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_ext;

    assign accept   = i_valid && (state_q == S_IDLE);
    assign tmo_last = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Decode of the incoming op: illegal width codes and misaligned H/W
    always_comb begin
        illegal_in  = 1'b0;
        misalign_in = 1'b0;
        if (i_is_store) begin
            illegal_in = (i_funct3 > 3'd2);
        end else begin
            illegal_in = (i_funct3 == 3'd3) || (i_funct3[2:1] == 2'b11);
        end
        if (i_funct3[1:0] == 2'b01) begin
            misalign_in = i_addr[0];
        end else if (i_funct3[1:0] == 2'b10) begin
            misalign_in = (i_addr[1:0] != 2'b00);
        end
    end

    // State register, fault cause and timeout counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            cause_q <= 2'd0;
            cnt_q   <= '0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: illegal beats misaligned; grant/rvalid beat the timeout
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (illegal_in) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (misalign_in) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_grant) begin
                    state_d = is_store_q ? S_RESP : S_WAIT_R;
                end else if (tmo_last) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WAIT_R: begin
                if (i_mem_rvalid) begin
                    state_d = S_RESP;
                end else if (tmo_last) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Timeout counter: cleared on accept, counts REQ/WAIT_R cycles, saturates
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if ((state_q == S_REQ || state_q == S_WAIT_R) && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Load lane select and sign/zero extension
    always_comb begin
        ld_byte = 8'h00;
        unique case (addr_q[1:0])
            2'd0: ld_byte = i_mem_rdata[7:0];
            2'd1: ld_byte = i_mem_rdata[15:8];
            2'd2: ld_byte = i_mem_rdata[23:16];
            2'd3: ld_byte = i_mem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        unique case (funct3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'h000000, ld_byte};
            3'd5:    ld_ext = {16'h0000, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
        rdata_d = rdata_q;
        if (state_q == S_WAIT_R && i_mem_rvalid) begin
            rdata_d = ld_ext;
        end
    end

    // Op latch on accept; load result register survives stores and faults
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            rdata_q    <= '0;
        end else if (i_clk_en) begin
            if (accept) begin
                is_store_q <= i_is_store;
                funct3_q   <= i_funct3;
                addr_q     <= i_addr;
                wdata_q    <= i_wdata;
                rd_q       <= i_rd;
            end
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from state; the request is held from latched fields
    always_comb begin
        o_ready       = (state_q == S_IDLE);
        o_mem_read    = (state_q == S_REQ) && !is_store_q;
        o_mem_write   = (state_q == S_REQ) && is_store_q;
        o_mem_addr    = {addr_q[AW-1:2], 2'b00};
        o_mem_byte_en = 4'b0000;
        o_mem_wdata   = '0;
        if (o_mem_write) begin
            unique case (funct3_q[1:0])
                2'b00: begin
                    o_mem_byte_en = 4'b0001 << addr_q[1:0];
                    o_mem_wdata   = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    o_mem_byte_en = 4'b0011 << addr_q[1:0];
                    o_mem_wdata   = {2{wdata_q[15:0]}};
                end
                default: begin
                    o_mem_byte_en = 4'b1111;
                    o_mem_wdata   = wdata_q;
                end
            endcase
        end
        o_done        = (state_q == S_RESP);
        o_rd_we       = (state_q == S_RESP) && !is_store_q;
        o_rd          = rd_q;
        o_rdata       = rdata_q;
        o_fault       = (state_q == S_FAULT);
        o_fault_cause = (state_q == S_FAULT) ? cause_q : 2'd0;
    end

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed spec cases plus random ops against a queue-based
// reference model; a negedge monitor checks requests and responses.
`timescale 1ns/1ps
module tb_core_lsu;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        valid = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        grant = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        o_ready, o_mem_read, o_mem_write, o_done, o_rd_we, o_fault;
    logic [31:0] o_mem_addr, o_mem_wdata, o_rdata;
    logic [3:0]  o_mem_byte_en;
    logic [4:0]  o_rd;
    logic [1:0]  o_fault_cause;

    core_lsu #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(clk_en),
        .i_valid(valid), .o_ready(o_ready), .i_is_store(is_store),
        .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata), .i_rd(rd),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_addr(o_mem_addr), .o_mem_byte_en(o_mem_byte_en),
        .o_mem_wdata(o_mem_wdata), .i_mem_grant(grant),
        .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
        .o_done(o_done), .o_rd_we(o_rd_we), .o_rd(o_rd), .o_rdata(o_rdata),
        .o_fault(o_fault), .o_fault_cause(o_fault_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit fault; bit [1:0] cause; bit rd_we; bit [4:0] rd; bit [31:0] rdata; int cyc; } resp_t;
    typedef struct { bit wr; bit [31:0] addr; bit [3:0] be; bit [31:0] wdata; } req_t;

    resp_t     resp_q[$];
    req_t      req_q[$];
    int        n_chk = 0;
    int        n_fail = 0;
    bit [31:0] last_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference load extraction from the RISC-V width/sign rules
    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] w);
        bit [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'h10000   : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Monitor: compares every visible request cycle and every response pulse
    bit prev_grant = 1'b0;
    always @(negedge clk) begin
        resp_t e;
        if (rst_n && clk_en) begin
            if (prev_grant) chk("req_drop", {31'd0, o_mem_read | o_mem_write}, 32'd0);
            prev_grant = grant && (o_mem_read || o_mem_write);
            if (o_mem_read || o_mem_write) begin
                if (req_q.size() == 0) fail_now("req_unexpected");
                else begin
                    chk("req_write", {31'd0, o_mem_write}, {31'd0, req_q[0].wr});
                    chk("req_read", {31'd0, o_mem_read}, {31'd0, !req_q[0].wr});
                    chk("req_addr", o_mem_addr, req_q[0].addr);
                    chk("req_be", {28'd0, o_mem_byte_en}, {28'd0, req_q[0].be});
                    if (req_q[0].wr) chk("req_wdata", o_mem_wdata, req_q[0].wdata);
                end
            end
            if (o_done || o_fault) begin
                if (resp_q.size() == 0) fail_now("resp_unexpected");
                else begin
                    e = resp_q.pop_front();
                    chk("resp_fault", {31'd0, o_fault}, {31'd0, e.fault});
                    chk("resp_done", {31'd0, o_done}, {31'd0, !e.fault});
                    if (e.fault) chk("fault_cause", {30'd0, o_fault_cause}, {30'd0, e.cause});
                    else begin
                        chk("rd_we", {31'd0, o_rd_we}, {31'd0, e.rd_we});
                        if (e.rd_we) chk("rd", {27'd0, o_rd}, {27'd0, e.rd});
                        chk("rdata", o_rdata, e.rdata);
                    end
                    if (e.cyc >= 0) chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 50 && !o_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!o_ready) fail_now("ready_timeout");
    endtask

    // One op: d idle-grant cycles, r idle-rvalid cycles, f disabled cycles before rvalid
    task automatic do_op(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                         input bit [4:0] dst, input int d, input int r, input int f,
                         input bit [31:0] word, input bit chk_lat);
        int    n, ent, size, lo, lim, rvi, last;
        bit    illegal, mis;
        resp_t e;
        req_t  q;
        wait_ready();
        n = cyc;
        valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rd = dst;
        @(posedge clk); #1;
        valid = 1'b0;
        is_store = $urandom; funct3 = $urandom; addr = $urandom; wdata = $urandom; rd = $urandom;
        ent = n + 1;
        size = 1 << f3[1:0];
        lo = a[1:0];
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
        e = '{fault: 1'b0, cause: 2'd0, rd_we: 1'b0, rd: dst, rdata: last_rdata, cyc: -1};
        if (illegal || mis) begin
            e.fault = 1'b1;
            e.cause = illegal ? 2'd2 : 2'd1;
            e.cyc = ent;
            resp_q.push_back(e);
        end else begin
            q.wr = st;
            q.addr = a & 32'hFFFF_FFFC;
            q.be = 4'd0;
            q.wdata = 32'd0;
            for (int j = 0; j < 4; j++) begin
                if (st && j >= lo && j < lo + size) q.be[j] = 1'b1;
                q.wdata |= ((wd >> (8 * (j % size))) & 32'hFF) << (8 * j);
            end
            req_q.push_back(q);
            lim = (T - 1 > d + 1) ? T - 1 : d + 1;
            rvi = d + 1 + r;
            if (d > T - 1) begin
                e.fault = 1'b1; e.cause = 2'd3; e.cyc = ent + T;
            end else if (st) begin
                e.cyc = ent + d + 1;
            end else if (rvi <= lim) begin
                last_rdata = m_load(f3, a, word);
                e.rd_we = 1'b1; e.rdata = last_rdata; e.cyc = ent + rvi + 1 + f;
            end else begin
                e.fault = 1'b1; e.cause = 2'd3; e.cyc = ent + lim + 1;
            end
            if (!chk_lat) e.cyc = -1;
            resp_q.push_back(e);
            last = st ? d : rvi;
            for (int i = 0; i <= last; i++) begin
                if (!st && i == rvi && f > 0) begin
                    clk_en = 1'b0; grant = 1'b0; rvalid = 1'b1; rdata = $urandom;
                    for (int k = 0; k < f; k++) begin
                        @(posedge clk); #1;
                        chk("freeze_no_resp", {31'd0, o_done | o_fault}, 32'd0);
                    end
                    clk_en = 1'b1;
                end
                grant = (i == d);
                rvalid = !st && (i == rvi);
                rdata = rvalid ? word : $urandom;
                @(posedge clk); #1;
            end
            grant = 1'b0; rvalid = 1'b0;
        end
        for (int k = 0; k < 40 && resp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (resp_q.size() != 0) begin
            fail_now("resp_timeout");
            resp_q.delete();
        end
        req_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_req", {30'd0, o_mem_read, o_mem_write}, 32'd0);
        chk("rst_resp", {30'd0, o_done, o_fault}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic width/extension cases and exact zero-wait latency
        do_op(0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 0, 0, 32'hDEADBEEF, 1);
        do_op(0, 3'd0, 32'h103, 32'h0, 5'd6, 0, 0, 0, 32'h80112233, 1);
        do_op(0, 3'd4, 32'h103, 32'h0, 5'd7, 0, 0, 0, 32'h80112233, 1);
        do_op(0, 3'd5, 32'h102, 32'h0, 5'd8, 0, 0, 0, 32'h80112233, 1);
        do_op(1, 3'd1, 32'h102, 32'h0000ABCD, 5'd9, 0, 0, 0, 32'h0, 1);
        do_op(1, 3'd0, 32'h201, 32'h12345677, 5'd1, 1, 0, 0, 32'h0, 1);
        // Faults: misaligned, illegal, illegal+misaligned
        do_op(0, 3'd2, 32'h101, 32'h0, 5'd2, 0, 0, 0, 32'h0, 1);
        do_op(1, 3'd3, 32'h100, 32'h0, 5'd2, 0, 0, 0, 32'h0, 1);
        do_op(1, 3'd5, 32'h101, 32'h0, 5'd2, 0, 0, 0, 32'h0, 1);
        do_op(0, 3'd6, 32'h103, 32'h0, 5'd2, 0, 0, 0, 32'h0, 1);
        // Timeout boundaries: final-cycle grant/rvalid wins
        do_op(1, 3'd2, 32'h40, 32'hCAFEF00D, 5'd3, 3, 0, 0, 32'h0, 1);
        do_op(1, 3'd2, 32'h40, 32'hCAFEF00D, 5'd3, 4, 0, 0, 32'h0, 1);
        do_op(0, 3'd2, 32'h44, 32'h0, 5'd4, 3, 0, 0, 32'h01020304, 1);
        do_op(0, 3'd2, 32'h48, 32'h0, 5'd4, 0, 3, 0, 32'h05060708, 1);
        do_op(0, 3'd1, 32'h4A, 32'h0, 5'd4, 0, 2, 0, 32'h9ABC0000, 1);
        // Clock enable low during WAIT_R with rvalid presented (must be ignored)
        do_op(0, 3'd2, 32'h300, 32'h0, 5'd10, 3, 0, 3, 32'h55AA33CC, 1);

        // Reset while the request is waiting for grant
        wait_ready();
        valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h304; rd = 5'd11;
        @(posedge clk); #1;
        valid = 1'b0;
        req_q.push_back('{wr: 1'b0, addr: 32'h304, be: 4'd0, wdata: 32'd0});
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_read", {31'd0, o_mem_read}, 32'd0);
        chk("midrst_ready", {31'd0, o_ready}, 32'd1);
        chk("midrst_resp", {30'd0, o_done, o_fault}, 32'd0);
        chk("midrst_rdata", o_rdata, 32'd0);
        chk("midrst_addr", o_mem_addr, 32'd0);
        req_q.delete();
        last_rdata = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Random mix of widths, alignments, delays and timeouts
        for (int t = 0; t < 200; t++) begin
            do_op($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 4), $urandom_range(0, 2), 0, $urandom, 1);
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
